// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multicycle multiply/divide unit.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in a dividend bit, subtract if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem, dividend_bit};
  // When the subtraction succeeds the difference is below the divisor, so W bits hold it.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle Booth multiplier / restoring divider feeding the HI/LO muxes.
// Optional macro UNSIGNED_OPS_EN adds the is_unsigned input (multu/divu).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef UNSIGNED_OPS_EN
  input  logic             is_unsigned,
`endif
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] high_out,
  output logic [WIDTH-1:0] low_out,
  output state_t           dbg_state
);

  // Handshake: start_* is a one-cycle request honoured only in IDLE; anything else is
  // dropped. done pulses one cycle when high_out/low_out carry the new result.

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH:0]   acc_hi;
  logic signed [WIDTH:0]   mcand;
  logic [WIDTH-1:0]        acc_lo;
  logic                    q_m1;
  logic                    corr;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        dvd;
  logic [WIDTH-1:0]        dvs;
  logic                    neg_q;
  logic                    neg_r;
  logic                    uns;

`ifdef UNSIGNED_OPS_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign dbg_state = state;

  logic signed [WIDTH:0] booth_sum;
  logic signed [WIDTH:0] nxt_hi;
  logic [WIDTH-1:0]      nxt_lo;
  logic [WIDTH-1:0]      mult_hi;

  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + mcand;
      2'b10:   booth_sum = acc_hi - mcand;
      default: booth_sum = acc_hi;
    endcase
  end

  assign nxt_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign nxt_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
  // Booth treats b as signed; an unsigned b with its MSB set needs a*2^W added back.
  assign mult_hi = nxt_hi[WIDTH-1:0] + (corr ? mcand[WIDTH-1:0] : '0);

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (rem),
    .dividend_bit (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  assign quo_next = {dvd[WIDTH-2:0], step_q};
  assign a_mag    = (!uns && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (!uns && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      mcand    <= '0;
      acc_lo   <= '0;
      q_m1     <= 1'b0;
      corr     <= 1'b0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      high_out <= '0;
      low_out  <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            mcand  <= uns ? {1'b0, a} : {a[WIDTH-1], a};
            acc_hi <= '0;
            acc_lo <= b;
            q_m1   <= 1'b0;
            corr   <= uns & b[WIDTH-1];
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            state  <= MULT;
          end else if (start_div) begin
            if (b == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= FIN;
            end else begin
              rem   <= '0;
              dvd   <= a_mag;
              dvs   <= b_mag;
              neg_q <= !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= !uns && a[WIDTH-1];
              cnt   <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          q_m1   <= acc_lo[0];
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            high_out <= mult_hi;
            low_out  <= nxt_lo;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        DIV: begin
          rem <= step_rem;
          dvd <= quo_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            low_out  <= neg_q ? -quo_next : quo_next;
            high_out <= neg_r ? -step_rem : step_rem;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
